sd_route_ctrl: RTL and testbench

SPI routing controller for the SD card path of the MSX core. It sits between the emsx MMC SPI master and the two possible SD targets: the HPS-backed virtual card (`sd_card`) and the physical SD-SPI pins. The block decides which target owns the bus. It switches ownership only when the bus is idle, with a guard gap. It also generates the optional reset-after-mount pulse and the SD activity indication.

---
 rtl/sd_route_ctrl.sv | 155 +++++++++++++++
 tb/tb_sd_route_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sd_route_ctrl.sv
// SD SPI route controller: picks virtual card vs physical pins, switching only on an idle bus.
// Optional activity detector built when SD_ROUTE_ACT_EN is defined; otherwise sd_act is tied 0.
module sd_route_ctrl #(
    parameter int IDLE_CYCLES  = 16,
    parameter int GUARD_CYCLES = 2,
    parameter int RST_CYCLES   = 64,
    parameter int ACT_TIMEOUT  = 1000000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       img_mounted,
    input  logic       img_present,
    input  logic       rst_on_mount,
    input  logic       spi_ss,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       vsd_ss,
    output logic       vsd_sck,
    output logic       vsd_mosi,
    input  logic       vsd_miso,
    output logic       sd_cs,
    output logic       sd_sck,
    output logic       sd_mosi,
    input  logic       sd_miso,
    output logic       vsd_sel,
    output logic       mount_reset,
    output logic       sd_act,
    output logic [1:0] state_dbg
);
    localparam int IW = $clog2(IDLE_CYCLES) + 1;
    localparam int GW = $clog2(GUARD_CYCLES) + 1;
    localparam int RW = $clog2(RST_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_WAIT_IDLE = 2'd1,
        S_GUARD     = 2'd2,
        S_MRST      = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idle_cnt;
    logic [GW-1:0] guard_cnt;
    logic [RW-1:0] rst_cnt;
    logic          pend_sel, pend_rst, mount_again, sel_r, gate;

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                // A live strobe wins over a deferred mount; both use the same decision rule.
                if (img_mounted) begin
                    if ((img_present != sel_r) || rst_on_mount) state_nxt = S_WAIT_IDLE;
                end else if (mount_again) begin
                    if ((pend_sel != sel_r) || pend_rst) state_nxt = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (spi_ss && (idle_cnt == IW'(IDLE_CYCLES))) state_nxt = S_GUARD;
            end
            S_GUARD: begin
                if (guard_cnt == GW'(GUARD_CYCLES - 1)) state_nxt = pend_rst ? S_MRST : S_RUN;
            end
            S_MRST: begin
                if (rst_cnt == RW'(RST_CYCLES - 1)) state_nxt = S_RUN;
            end
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= S_RUN;
            idle_cnt    <= '0;
            guard_cnt   <= '0;
            rst_cnt     <= '0;
            pend_sel    <= 1'b0;
            pend_rst    <= 1'b0;
            mount_again <= 1'b0;
            sel_r       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (img_mounted) begin
                pend_sel <= img_present;
                pend_rst <= rst_on_mount;
            end
            if (state == S_RUN)
                mount_again <= 1'b0;
            else if (img_mounted && ((state == S_GUARD) || (state == S_MRST)))
                mount_again <= 1'b1;

            // Any busy cycle restarts the idle window.
            if ((state != S_WAIT_IDLE) || !spi_ss)
                idle_cnt <= '0;
            else if (idle_cnt != IW'(IDLE_CYCLES))
                idle_cnt <= idle_cnt + IW'(1);

            if (state != S_GUARD)
                guard_cnt <= '0;
            else if (guard_cnt != GW'(GUARD_CYCLES - 1))
                guard_cnt <= guard_cnt + GW'(1);

            if (state != S_MRST)
                rst_cnt <= '0;
            else if (rst_cnt != RW'(RST_CYCLES - 1))
                rst_cnt <= rst_cnt + RW'(1);

            if ((state == S_WAIT_IDLE) && (state_nxt == S_GUARD))
                sel_r <= pend_sel;
        end
    end

    assign gate        = (state == S_GUARD);
    assign vsd_sel     = sel_r;
    assign mount_reset = (state == S_MRST);
    assign state_dbg   = state;

    assign sd_cs    = spi_ss | sel_r | gate;
    assign sd_sck   = spi_sck & ~sel_r & ~gate;
    assign sd_mosi  = spi_mosi & ~sel_r & ~gate;
    assign vsd_ss   = spi_ss | ~sel_r | gate;
    assign vsd_sck  = spi_sck & sel_r & ~gate;
    assign vsd_mosi = spi_mosi & sel_r & ~gate;
    assign spi_miso = sel_r ? vsd_miso : sd_miso;

`ifdef SD_ROUTE_ACT_EN
    localparam int AW = $clog2(ACT_TIMEOUT) + 1;

    logic [AW-1:0] act_cnt;
    logic          mosi_q, miso_q, act_r;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            act_cnt <= '0;
            mosi_q  <= 1'b0;
            miso_q  <= 1'b0;
            act_r   <= 1'b0;
        end else begin
            mosi_q <= spi_mosi;
            miso_q <= spi_miso;
            if ((spi_mosi != mosi_q) || (spi_miso != miso_q))
                act_cnt <= '0;
            else if (act_cnt != AW'(ACT_TIMEOUT))
                act_cnt <= act_cnt + AW'(1);
            act_r <= (act_cnt < AW'(ACT_TIMEOUT));
        end
    end

    assign sd_act = act_r;
`else
    assign sd_act = 1'b0;
`endif

endmodule

// File: tb/tb_sd_route_ctrl.sv
// Directed bench for sd_route_ctrl: stimulus pushes expected output edges (value, cycle) into
// per-signal queues; a negedge monitor pops and compares whenever an output changes.
module tb_sd_route_ctrl;
    localparam int ACT_TO = 50;
    localparam int W      = 33;

    logic clk_sys = 1'b0;
    logic reset = 1'b1;
    logic img_mounted = 1'b0, img_present = 1'b0, rst_on_mount = 1'b0;
    logic spi_ss = 1'b1, spi_sck = 1'b1, spi_mosi = 1'b0;
    logic vsd_miso = 1'b0, sd_miso = 1'b0;
    logic spi_miso, vsd_ss, vsd_sck, vsd_mosi, sd_cs, sd_sck, sd_mosi;
    logic vsd_sel, mount_reset, sd_act;
    logic [1:0] state_dbg;

    logic [31:0] cyc = '0;
    logic [W-1:0] exp_sel_q[$];
    logic [W-1:0] exp_rst_q[$];
    logic [W-1:0] exp_act_q[$];
    int n_checks = 0, n_pass = 0;
    int gate_cycles = 0, overlap_cycles = 0;
    logic mon_en = 1'b0;
    logic prev_sel = 1'b0, prev_rst = 1'b0, prev_act = 1'b0;
    logic [31:0] c, t0;

    sd_route_ctrl #(.ACT_TIMEOUT(ACT_TO)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .img_mounted(img_mounted), .img_present(img_present), .rst_on_mount(rst_on_mount),
        .spi_ss(spi_ss), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .vsd_ss(vsd_ss), .vsd_sck(vsd_sck), .vsd_mosi(vsd_mosi), .vsd_miso(vsd_miso),
        .sd_cs(sd_cs), .sd_sck(sd_sck), .sd_mosi(sd_mosi), .sd_miso(sd_miso),
        .vsd_sel(vsd_sel), .mount_reset(mount_reset), .sd_act(sd_act), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 32'd1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic check_evt(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got value %0b at cycle %0d, expected value %0b at cycle %0d",
                      name, got[W-1], got[31:0], exp[W-1], exp[31:0]);
    endtask

    task automatic mount(input logic present, input logic rst);
        img_present  = present;
        rst_on_mount = rst;
        img_mounted  = 1'b1;
        tick(1);
        img_mounted  = 1'b0;
    endtask

    task automatic check_miso(input string name);
        vsd_miso = 1'b1; sd_miso = 1'b0; #1;
        check({name, "_a"}, {31'd0, spi_miso}, {31'd0, vsd_sel_exp});
        vsd_miso = 1'b0; sd_miso = 1'b1; #1;
        check({name, "_b"}, {31'd0, spi_miso}, {31'd0, ~vsd_sel_exp});
        sd_miso = 1'b0; #1;
    endtask

    logic vsd_sel_exp = 1'b0;

    // monitor / scoreboard
    always @(negedge clk_sys) begin
        if (mon_en) begin
            if (vsd_sel !== prev_sel) begin
                if (exp_sel_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL vsd_sel_event: got unexpected change to %0b at cycle %0d, expected none", vsd_sel, cyc);
                end else check_evt("vsd_sel_event", {vsd_sel, cyc}, exp_sel_q.pop_front());
            end
            if (mount_reset !== prev_rst) begin
                if (exp_rst_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL mount_reset_event: got unexpected change to %0b at cycle %0d, expected none", mount_reset, cyc);
                end else check_evt("mount_reset_event", {mount_reset, cyc}, exp_rst_q.pop_front());
            end
            if (sd_act !== prev_act) begin
                if (exp_act_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sd_act_event: got unexpected change to %0b at cycle %0d, expected none", sd_act, cyc);
                end else check_evt("sd_act_event", {sd_act, cyc}, exp_act_q.pop_front());
            end
            if (spi_ss && spi_sck && !sd_sck && !vsd_sck) gate_cycles++;
            if (!sd_cs && !vsd_ss) overlap_cycles++;
        end
        prev_sel = vsd_sel;
        prev_rst = mount_reset;
        prev_act = sd_act;
    end

    initial begin
        // reset then idle
        tick(3);
        check("reset_vsd_sel", {31'd0, vsd_sel}, 32'd0);
        check("reset_mount_reset", {31'd0, mount_reset}, 32'd0);
        check("reset_sd_act", {31'd0, sd_act}, 32'd0);
        check("reset_state", {30'd0, state_dbg}, 32'd0);
        mon_en = 1'b1;
`ifdef SD_ROUTE_ACT_EN
        exp_act_q.push_back({1'b1, cyc + 32'd1});
        exp_act_q.push_back({1'b0, cyc + 32'd1 + 32'(ACT_TO)});
`endif
        reset = 1'b0;
        tick(60);
        check("idle_vsd_sel", {31'd0, vsd_sel}, 32'd0);

        // idle mount to virtual card, no reset
        t0 = cyc + 32'd1;
        exp_sel_q.push_back({1'b1, t0 + 32'd17});
        mount(1'b1, 1'b0);
        tick(25);
        vsd_sel_exp = 1'b1;
        check_miso("miso_vsd");

        // mount back to pins during a 100-cycle transfer
        c = cyc;
        exp_sel_q.push_back({1'b0, c + 32'd117});
`ifdef SD_ROUTE_ACT_EN
        exp_act_q.push_back({1'b1, c + 32'd2});
        exp_act_q.push_back({1'b0, c + 32'd52});
        exp_act_q.push_back({1'b1, c + 32'd102});
        exp_act_q.push_back({1'b0, c + 32'd152});
`endif
        spi_ss = 1'b0;
        spi_mosi = 1'b1;
        mount(1'b0, 1'b0);
        for (int i = 1; i < 100; i++) begin
            spi_sck = ~spi_sck;
            tick(1);
            if (i == 10) begin
                check("xfer_sd_cs", {31'd0, sd_cs}, 32'd1);
                check("xfer_vsd_ss", {31'd0, vsd_ss}, 32'd0);
                check("xfer_vsd_mosi", {31'd0, vsd_mosi}, 32'd1);
                check("xfer_sd_mosi", {31'd0, sd_mosi}, 32'd0);
                check("xfer_vsd_sck", {31'd0, vsd_sck}, {31'd0, spi_sck});
            end
        end
        spi_ss = 1'b1;
        spi_mosi = 1'b0;
        spi_sck = 1'b1;
        tick(60);
        vsd_sel_exp = 1'b0;
        check_miso("miso_sd");

        // same target with reset after mount
        t0 = cyc + 32'd1;
        exp_rst_q.push_back({1'b1, t0 + 32'd19});
        exp_rst_q.push_back({1'b0, t0 + 32'd83});
        mount(1'b0, 1'b1);
        tick(90);

        // second mount lands during MRST
        t0 = cyc + 32'd1;
        exp_sel_q.push_back({1'b1, t0 + 32'd17});
        exp_rst_q.push_back({1'b1, t0 + 32'd19});
        exp_rst_q.push_back({1'b0, t0 + 32'd83});
        exp_sel_q.push_back({1'b0, t0 + 32'd101});
        mount(1'b1, 1'b1);
        tick(29);
        mount(1'b0, 1'b0);
        tick(80);

        // reset asserted during MRST
        t0 = cyc + 32'd1;
        exp_sel_q.push_back({1'b1, t0 + 32'd17});
        exp_rst_q.push_back({1'b1, t0 + 32'd19});
        exp_rst_q.push_back({1'b0, t0 + 32'd40});
        exp_sel_q.push_back({1'b0, t0 + 32'd40});
        mount(1'b1, 1'b1);
        tick(39);
        reset = 1'b1;
        tick(1);
        check("midreset_mount_reset", {31'd0, mount_reset}, 32'd0);
        check("midreset_state", {30'd0, state_dbg}, 32'd0);
        check("midreset_vsd_sel", {31'd0, vsd_sel}, 32'd0);
        tick(1);
`ifdef SD_ROUTE_ACT_EN
        exp_act_q.push_back({1'b1, cyc + 32'd1});
        exp_act_q.push_back({1'b0, cyc + 32'd1 + 32'(ACT_TO)});
`endif
        reset = 1'b0;
        tick(60);

        // final report
        check("guard_cycles", gate_cycles, 32'd12);
        check("both_selected_cycles", overlap_cycles, 32'd0);
        check("pending_vsd_sel_events", exp_sel_q.size(), 32'd0);
        check("pending_mount_reset_events", exp_rst_q.size(), 32'd0);
        check("pending_sd_act_events", exp_act_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
